// File: rtl/serial_bus_responder.sv
// serial_bus_responder
//   Far end of the single-wire serial bus link. Decodes 13-bit frames
//   (0,1,F,D[7:0],0,0, MSB first) from serialin, collects data bytes into a
//   32-bit accumulator, and on a command frame executes one read or write on
//   the local register bus. It then shifts a three-frame reply (read data hi,
//   read data lo, status) back out on serialout.
//
// Ports
//   clk        system clock
//   rst_n      synchronous active-low reset
//   serialin   serial command stream from the initiator
//   serialout  serial reply stream to the initiator
//   wr         one-cycle bus write strobe
//   addr       bus address (holds until the next command executes)
//   wrdata     bus write data (holds until the next command executes)
//   rddata     bus read data, combinational function of addr
//   rdcount    completed reads
//   wrcount    completed writes
//   bytecount  frames received
//   errcount   unrecognised command bytes
module serial_bus_responder #(
  parameter logic [7:0] CMD_WRITE = 8'h01,
  parameter logic [7:0] CMD_READ  = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        serialin,
  output logic        serialout,
  output logic        wr,
  output logic [15:0] addr,
  output logic [15:0] wrdata,
  input  logic [15:0] rddata,
  output logic [15:0] rdcount,
  output logic [15:0] wrcount,
  output logic [15:0] bytecount,
  output logic [15:0] errcount
);

  typedef enum logic [1:0] {IDLE, EXEC, CAPTURE, REPLY} state_t;

  state_t      state_q, state_d;
  logic        sin_q, sin_d;
  logic [11:0] sr_q, sr_d;
  logic [31:0] acc_q, acc_d;
  logic [7:0]  cmd_q, cmd_d;
  logic        pend_q, pend_d;
  logic [7:0]  pend_cmd_q, pend_cmd_d;
  logic [37:0] shift_q, shift_d;
  logic [5:0]  bitcnt_q, bitcnt_d;
  logic        serialout_q, serialout_d;
  logic        wr_q, wr_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wrdata_q, wrdata_d;
  logic [15:0] rdcount_q, rdcount_d;
  logic [15:0] wrcount_q, wrcount_d;
  logic [15:0] bytecount_q, bytecount_d;
  logic [15:0] errcount_q, errcount_d;

  logic        frame_det, cmd_det, data_det;
  logic [7:0]  frame_byte;
  logic        exec_go;
  logic [7:0]  exec_cmd;
  logic [15:0] rd_lat;
  logic [7:0]  status;
  logic [38:0] reply;

  // Three reply frames: read data hi, read data lo, then the flagged status frame.
  function automatic logic [38:0] build_reply(input logic [15:0] rd, input logic [7:0] st);
    return {3'b010, rd[15:8], 2'b00, 3'b010, rd[7:0], 2'b00, 3'b011, st, 2'b00};
  endfunction

  always_comb begin
    state_d     = state_q;
    sin_d       = serialin;
    acc_d       = acc_q;
    cmd_d       = cmd_q;
    pend_d      = pend_q;
    pend_cmd_d  = pend_cmd_q;
    shift_d     = shift_q;
    bitcnt_d    = bitcnt_q;
    serialout_d = 1'b0;
    wr_d        = 1'b0;
    addr_d      = addr_q;
    wrdata_d    = wrdata_q;
    rdcount_d   = rdcount_q;
    wrcount_d   = wrcount_q;
    errcount_d  = errcount_q;
    exec_go     = 1'b0;
    exec_cmd    = 8'h00;
    rd_lat      = 16'h0000;
    status      = 8'h00;
    reply       = 39'd0;

    // Receive stage: the shifter holds 1,F,D[7:0],0,0 once a full frame is in.
    frame_det   = sr_q[11] & (sr_q[1:0] == 2'b00);
    frame_byte  = sr_q[9:2];
    cmd_det     = frame_det & sr_q[10];
    data_det    = frame_det & ~sr_q[10];
    sr_d        = frame_det ? 12'd0 : {sr_q[10:0], sin_q};
    bytecount_d = bytecount_q + 16'(frame_det);

    // Control stage
    unique case (state_q)
      IDLE: begin
        if (cmd_det) begin
          exec_go  = 1'b1;
          exec_cmd = frame_byte;
        end
      end
      EXEC: begin
        // A command landing here is parked and run straight after CAPTURE.
        if (cmd_det) begin
          pend_d     = 1'b1;
          pend_cmd_d = frame_byte;
        end
        state_d = CAPTURE;
      end
      CAPTURE: begin
        rd_lat = (cmd_q == CMD_READ) ? rddata : 16'h0000;
        status = {(cmd_q != CMD_WRITE) && (cmd_q != CMD_READ), 5'b00000,
                  cmd_q == CMD_WRITE, 1'b1};
        reply  = build_reply(rd_lat, status);
        if (cmd_det) begin
          exec_go  = 1'b1;
          exec_cmd = frame_byte;
        end else if (pend_q) begin
          exec_go  = 1'b1;
          exec_cmd = pend_cmd_q;
          pend_d   = 1'b0;
        end else begin
          // First bit goes straight to the line; the rest wait in the shifter.
          serialout_d = reply[38];
          shift_d     = reply[37:0];
          bitcnt_d    = 6'd0;
          state_d     = REPLY;
        end
      end
      REPLY: begin
        if (cmd_det) begin
          exec_go  = 1'b1;
          exec_cmd = frame_byte;
        end else if (bitcnt_q == 6'd38) begin
          state_d = IDLE;
        end else begin
          serialout_d = shift_q[37];
          shift_d     = {shift_q[36:0], 1'b0};
          bitcnt_d    = bitcnt_q + 6'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Execute stage: bus fields are latched on entry so they are valid during EXEC.
    if (exec_go) begin
      state_d     = EXEC;
      serialout_d = 1'b0;
      cmd_d       = exec_cmd;
      addr_d      = acc_q[15:0];
      wrdata_d    = acc_q[31:16];
      acc_d       = 32'd0;
      if (exec_cmd == CMD_WRITE) begin
        wr_d      = 1'b1;
        wrcount_d = wrcount_q + 16'd1;
      end else if (exec_cmd == CMD_READ) begin
        rdcount_d = rdcount_q + 16'd1;
      end else begin
        errcount_d = errcount_q + 16'd1;
      end
    end

    if (data_det) begin
      acc_d = {acc_d[23:0], frame_byte};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sin_q       <= 1'b0;
      sr_q        <= 12'd0;
      acc_q       <= 32'd0;
      cmd_q       <= 8'h00;
      pend_q      <= 1'b0;
      pend_cmd_q  <= 8'h00;
      shift_q     <= 38'd0;
      bitcnt_q    <= 6'd0;
      serialout_q <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= 16'h0000;
      wrdata_q    <= 16'h0000;
      rdcount_q   <= 16'h0000;
      wrcount_q   <= 16'h0000;
      bytecount_q <= 16'h0000;
      errcount_q  <= 16'h0000;
    end else begin
      state_q     <= state_d;
      sin_q       <= sin_d;
      sr_q        <= sr_d;
      acc_q       <= acc_d;
      cmd_q       <= cmd_d;
      pend_q      <= pend_d;
      pend_cmd_q  <= pend_cmd_d;
      shift_q     <= shift_d;
      bitcnt_q    <= bitcnt_d;
      serialout_q <= serialout_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wrdata_q    <= wrdata_d;
      rdcount_q   <= rdcount_d;
      wrcount_q   <= wrcount_d;
      bytecount_q <= bytecount_d;
      errcount_q  <= errcount_d;
    end
  end

  assign serialout = serialout_q;
  assign wr        = wr_q;
  assign addr      = addr_q;
  assign wrdata    = wrdata_q;
  assign rdcount   = rdcount_q;
  assign wrcount   = wrcount_q;
  assign bytecount = bytecount_q;
  assign errcount  = errcount_q;

endmodule
